// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers returned
// words in a small FIFO and drops stale words after a taken branch/jump from execute.
module fetch_unit #(
  parameter int                 D_WIDTH  = 32,
  parameter logic [D_WIDTH-1:0] RESET_PC = '0,
  parameter int                 DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   pcsrc,
  input  logic [D_WIDTH-1:0]     jumpaddress,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [D_WIDTH-1:0]     imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr,
  output logic [D_WIDTH-1:0]     prog_addr,
  output logic                   dbg_state,
  output logic [$clog2(DEPTH):0] dbg_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [D_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]      outstanding_q, outstanding_d;
  logic [CW-1:0]      drop_cnt_q, drop_cnt_d;
  logic [0:0]         state_q, state_d;
  logic               req_valid_q, req_valid_d;

  logic [D_WIDTH-1:0] tag_mem_q [DEPTH];
  logic [AW-1:0]      tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [31:0]        fifo_instr_q [DEPTH];
  logic [D_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [AW-1:0]      fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [CW-1:0]      count_q, count_d;

  logic redirect, req_fire, rsp_fire, pop, push;
  logic unused_jump_lo;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends combinationally on ready. Responses have no ready and always fit.
  assign redirect = ex_valid & pcsrc;
  assign req_fire = req_valid_q & imem_req_ready;
  assign rsp_fire = imem_rsp_valid;
  assign pop      = instr_valid & instr_ready;
  assign push     = rsp_fire & (state_q == ST_RUN) & ~redirect;

  assign unused_jump_lo = ^jumpaddress[1:0];

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    drop_cnt_d    = drop_cnt_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    count_d       = count_q;

    if (redirect) begin
      pc_d = {jumpaddress[D_WIDTH-1:2], 2'b00};
    end else if (req_fire) begin
      pc_d = pc_q + D_WIDTH'(4);
    end

    // Every word still owed by imem at a redirect is stale, including one requested now.
    if (redirect) begin
      drop_cnt_d = outstanding_d;
    end else if ((state_q == ST_FLUSH) && rsp_fire) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    if (redirect) begin
      tag_wr_d  = '0;
      tag_rd_d  = '0;
      fifo_wr_d = '0;
      fifo_rd_d = '0;
      count_d   = '0;
    end else begin
      if (req_fire) tag_wr_d = tag_wr_q + AW'(1);
      if (rsp_fire && (state_q == ST_RUN)) tag_rd_d = tag_rd_q + AW'(1);
      if (push) fifo_wr_d = fifo_wr_q + AW'(1);
      if (pop) fifo_rd_d = fifo_rd_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    state_d     = (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
    req_valid_d = (({1'b0, outstanding_d} + {1'b0, count_d}) < DEPTH_S) && (drop_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      state_q       <= ST_RUN;
      req_valid_q   <= 1'b0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
        fifo_addr_q[i]  <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= state_d;
      req_valid_q   <= req_valid_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      count_q       <= count_d;
      if (req_fire && !redirect) tag_mem_q[tag_wr_q] <= pc_q;
      if (push) begin
        fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
        fifo_addr_q[fifo_wr_q]  <= tag_mem_q[tag_rd_q];
      end
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = (count_q != '0);
  assign instr          = fifo_instr_q[fifo_rd_q];
  assign prog_addr      = fifo_addr_q[fifo_rd_q];
  assign dbg_state      = state_q;
  assign dbg_drop_cnt   = drop_cnt_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_fire && (outstanding_q == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && (outstanding_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order imem model with adjustable latency, a delivery
// log, and hand-computed expectations for reset, backpressure, redirects and async reset.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] jumpaddress = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] prog_addr;
  logic        dbg_state;
  logic [1:0]  dbg_drop_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int mem_lat  = 1;
  logic mem_ready = 1'b1;
  int cyc = 0;

  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];
  logic [31:0] req_addr_q[$];
  logic [31:0] got_addr_q[$];
  logic [31:0] got_instr_q[$];

  fetch_unit #(.D_WIDTH(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .pcsrc          (pcsrc),
    .jumpaddress    (jumpaddress),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .prog_addr      (prog_addr),
    .dbg_state      (dbg_state),
    .dbg_drop_cnt   (dbg_drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // imem model: answers in request order, mem_lat cycles after acceptance
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      pend_addr_q.delete();
      pend_due_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_req_ready = mem_ready;
    end else begin
      if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(pend_addr_q.pop_front());
        void'(pend_due_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      imem_req_ready = mem_ready;
      if (imem_req_valid && imem_req_ready) begin
        pend_addr_q.push_back(imem_addr);
        pend_due_q.push_back(cyc + mem_lat);
        req_addr_q.push_back(imem_addr);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && instr_valid && instr_ready && !(ex_valid && pcsrc)) begin
      got_addr_q.push_back(prog_addr);
      got_instr_q.push_back(instr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k = 0;
    while (got_addr_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(got_addr_q.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input int n, input int budget, input string tag);
    int k = 0;
    while (req_addr_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(req_addr_q.size() >= n), 32'd1);
  endtask

  task automatic wait_two_inflight(input string tag);
    int k = 0;
    while (!(pend_addr_q.size() == 2 && !imem_req_valid) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(pend_addr_q.size()), 32'd2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    ex_valid = 1'b0;
    pcsrc    = 1'b0;
    repeat (2) @(negedge clk);
    got_addr_q.delete();
    got_instr_q.delete();
    req_addr_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    ex_valid    = 1'b1;
    pcsrc       = 1'b1;
    jumpaddress = target;
    @(negedge clk);
    ex_valid = 1'b0;
    pcsrc    = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_prog_addr", prog_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_drop_cnt", 32'(dbg_drop_cnt), 32'd0);

    // sequential fetch, always-ready 1-cycle imem and decode
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_got(4, 50, "t1_timeout");
    if (got_addr_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t1_addr%0d", i), got_addr_q[i], 32'(i * 4));
        check($sformatf("t1_instr%0d", i), got_instr_q[i], word_of(32'(i * 4)));
      end
    end

    // decode stalled: credit caps requests at DEPTH
    instr_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check("t2_req_count", 32'(req_addr_q.size()), 32'(DEPTH));
    check("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
    check("t2_instr_valid", 32'(instr_valid), 32'd1);
    check("t2_head_addr", prog_addr, 32'h0);
    check("t2_head_instr", instr, word_of(32'h0));
    check("t2_imem_addr", imem_addr, 32'h8);
    instr_ready = 1'b1;
    wait_got(3, 50, "t2_timeout");
    if (got_addr_q.size() >= 3) begin
      check("t2_pop0", got_addr_q[0], 32'h0);
      check("t2_pop1", got_addr_q[1], 32'h4);
      check("t2_pop2", got_addr_q[2], 32'h8);
    end
    if (req_addr_q.size() >= 3) check("t2_resume_req", req_addr_q[2], 32'h8);

    // redirect with two slow fetches in flight
    mem_lat = 3;
    do_reset();
    wait_two_inflight("t3_inflight");
    redirect_to(32'h100);
    check("t3_instr_valid_low", 32'(instr_valid), 32'd0);
    check("t3_state_flush", 32'(dbg_state), 32'(ST_FLUSH));
    check("t3_drop_cnt", 32'(dbg_drop_cnt), 32'd2);
    check("t3_imem_addr", imem_addr, 32'h100);
    check("t3_req_blocked", 32'(imem_req_valid), 32'd0);
    got_addr_q.delete();
    got_instr_q.delete();
    @(negedge clk);
    check("t3_drop_dec", 32'(dbg_drop_cnt), 32'd1);
    wait_got(1, 50, "t3_timeout");
    if (got_addr_q.size() >= 1) begin
      check("t3_first_addr", got_addr_q[0], 32'h100);
      check("t3_first_instr", got_instr_q[0], word_of(32'h100));
    end

    // unaligned jump target is word aligned
    mem_lat = 1;
    do_reset();
    repeat (5) @(negedge clk);
    redirect_to(32'h203);
    req_addr_q.delete();
    got_addr_q.delete();
    got_instr_q.delete();
    check("t4_imem_addr", imem_addr, 32'h200);
    wait_req(2, 20, "t4_req_timeout");
    if (req_addr_q.size() >= 2) begin
      check("t4_req0", req_addr_q[0], 32'h200);
      check("t4_req1", req_addr_q[1], 32'h204);
    end
    wait_got(1, 50, "t4_timeout");
    if (got_addr_q.size() >= 1) check("t4_first_addr", got_addr_q[0], 32'h200);

    // redirect coinciding with rsp_fire and pop
    do_reset();
    repeat (3) @(negedge clk);
    check("t5_pre_valid", 32'(instr_valid), 32'd1);
    check("t5_pre_head", prog_addr, 32'h0);
    check("t5_pre_rsp_due", 32'(pend_addr_q.size()), 32'd1);
    redirect_to(32'h40);
    check("t5_instr_valid_low", 32'(instr_valid), 32'd0);
    check("t5_drop_cnt", 32'(dbg_drop_cnt), 32'd0);
    check("t5_state_run", 32'(dbg_state), 32'(ST_RUN));
    check("t5_imem_addr", imem_addr, 32'h40);
    check("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_no_pop", 32'(got_addr_q.size()), 32'd0);
    wait_got(1, 50, "t5_timeout");
    if (got_addr_q.size() >= 1) begin
      check("t5_first_addr", got_addr_q[0], 32'h40);
      check("t5_first_instr", got_instr_q[0], word_of(32'h40));
    end

    // asynchronous reset while flushing
    mem_lat = 3;
    do_reset();
    wait_two_inflight("t6_inflight");
    redirect_to(32'h100);
    check("t6_pre_state", 32'(dbg_state), 32'(ST_FLUSH));
    check("t6_pre_drop", 32'(dbg_drop_cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_drop_cnt", 32'(dbg_drop_cnt), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_RUN));
    check("t6_instr_valid", 32'(instr_valid), 32'd0);
    check("t6_imem_addr", imem_addr, 32'h0);
    check("t6_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (2) @(negedge clk);
    got_addr_q.delete();
    got_instr_q.delete();
    req_addr_q.delete();
    rst_n = 1'b1;
    wait_got(2, 60, "t6_timeout");
    if (got_addr_q.size() >= 2) begin
      check("t6_after0", got_addr_q[0], 32'h0);
      check("t6_after1", got_addr_q[1], 32'h4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
